// File: rtl/seg_digit_sequencer_pkg.sv
// seg_digit_sequencer_pkg: shared RUN/PAUSE state type and counter width constants.
package seg_digit_sequencer_pkg;
    typedef enum logic {ST_RUN = 1'b0, ST_PAUSE = 1'b1} state_t;
    localparam int TICK_W = 24;
    localparam int DEB_W  = 20;
endpackage

// File: rtl/seg_btn_debounce.sv
// seg_btn_debounce: 2-flop synchronizer, stability debouncer and one-cycle press pulse.
module seg_btn_debounce
    import seg_digit_sequencer_pkg::*;
#(
    parameter int DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);
    logic [1:0]       r_sync;
    logic [DEB_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             w_differ;
    logic             w_accept;

    assign w_differ = r_sync[1] != r_level;
    assign w_accept = w_differ && (r_cnt == DEB_W'(DEB_CYCLES - 1));
    assign o_level  = r_level;
    assign o_press  = r_press;

    // Accept a new level once it has differed for DEB_CYCLES consecutive cycles; pulse on rise only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_cnt   <= (w_differ && !w_accept) ? r_cnt + 1'b1 : '0;
            r_level <= w_accept ? r_sync[1] : r_level;
            r_press <= w_accept && r_sync[1];
        end
    end
endmodule

// File: rtl/seg_digit_sequencer.sv
// seg_digit_sequencer: hex digit with auto-advance tick, up/down step and run/pause buttons.
// Define SEQ_AUTOREPEAT_EN to add hold-to-repeat stepping on the up/down buttons.
module seg_digit_sequencer
    import seg_digit_sequencer_pkg::*;
#(
    parameter int TICK_DIV   = 10000000,
    parameter int DEB_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_run,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       running
);
    logic              w_up_lvl, w_up_press;
    logic              w_dn_lvl, w_dn_press;
    logic              w_run_lvl, w_run_press;
    logic              w_lvl_unused;
    logic [1:0]        w_rep;
    logic              w_up, w_dn, w_step, w_term;
    state_t            r_state, w_state_next;
    logic [TICK_W-1:0] r_tick, w_tick_next;
    logic [3:0]        r_digit, w_digit_next;
    logic              r_valid;

    seg_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_up), .o_level(w_up_lvl), .o_press(w_up_press)
    );
    seg_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_down (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_down), .o_level(w_dn_lvl), .o_press(w_dn_press)
    );
    seg_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_run), .o_level(w_run_lvl), .o_press(w_run_press)
    );

    assign w_lvl_unused = ^{w_run_lvl, w_up_lvl, w_dn_lvl};

`ifdef SEQ_AUTOREPEAT_EN
    localparam logic [TICK_W-1:0] REP_FIRST = TICK_W'(TICK_DIV / 2);
    localparam logic [TICK_W-1:0] REP_NEXT  = TICK_W'(((TICK_DIV / 8) > 1 ? (TICK_DIV / 8) : 1) - 1);
    logic [1:0] w_hold;
    assign w_hold = {w_dn_lvl, w_up_lvl};
    for (genvar g = 0; g < 2; g++) begin : g_rep
        logic [TICK_W-1:0] r_cnt;
        logic              r_first;
        assign w_rep[g] = w_hold[g] && (r_cnt == (r_first ? REP_FIRST : REP_NEXT));
        // Count cycles a button is held; first repeat after half a tick period, then every eighth.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_first <= 1'b1;
            end else begin
                r_cnt   <= (!w_hold[g] || w_rep[g]) ? '0 : r_cnt + 1'b1;
                r_first <= !w_hold[g] ? 1'b1 : (w_rep[g] ? 1'b0 : r_first);
            end
        end
    end
`else
    assign w_rep = 2'b00;
`endif

    assign w_up   = w_up_press | w_rep[0];
    assign w_dn   = w_dn_press | w_rep[1];
    assign w_step = w_up | w_dn;
    assign w_term = (r_state == ST_RUN) && (r_tick == TICK_W'(TICK_DIV - 1));

    assign digit       = r_digit;
    assign digit_valid = r_valid;
    assign running     = r_state == ST_RUN;

    // RUN/PAUSE state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_next;
    end

    // Next state, digit and tick: a step wins over a terminal tick and always restarts the tick period.
    always_comb begin
        w_state_next = w_run_press ? ((r_state == ST_RUN) ? ST_PAUSE : ST_RUN) : r_state;
        w_digit_next = (w_up && !w_dn) ? r_digit + 4'd1 :
                       (w_dn && !w_up) ? r_digit - 4'd1 :
                       (!w_step && w_term) ? r_digit + 4'd1 : r_digit;
        w_tick_next  = (w_step || w_term || r_state != ST_RUN || w_state_next != ST_RUN) ? '0 : r_tick + 1'b1;
    end

    // Digit, tick counter and one-cycle change strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= 4'd0;
            r_tick  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_digit <= w_digit_next;
            r_tick  <= w_tick_next;
            r_valid <= w_digit_next != r_digit;
        end
    end
endmodule

// File: tb/tb_seg_digit_sequencer.sv
// tb_seg_digit_sequencer: directed table, hand sequences and randomized run against a reference model.
module tb_seg_digit_sequencer;
    localparam int TD = 10;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_run = 1'b0;
    logic [3:0] digit;
    logic       digit_valid, running;
    int         checks = 0, failures = 0;
    int         ecount = 0;

    always #5 clk = ~clk;

    seg_digit_sequencer #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .btn_run(btn_run),
        .digit(digit), .digit_valid(digit_valid), .running(running)
    );

    // rising edges since reset release
    always @(posedge clk or negedge rst_n) ecount <= !rst_n ? 0 : ecount + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, ecount, $time);
        end
    endtask

    task automatic at(int k);
        int guard = 0;
        while (ecount < k && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (ecount < k) chk("at_timeout", ecount, k);
    endtask

    task automatic do_reset();
        btn_up = 0; btn_down = 0; btn_run = 0;
        @(negedge clk); rst_n = 0;
        @(negedge clk); @(negedge clk); rst_n = 1;
    endtask

    // ---------------- reference model ----------------
    // Debounced level flips when the last DB synchronized samples (raw delayed two edges) all
    // disagree with it; digit/tick follow the tick, step, cancel and run-toggle rules.
    bit hist [3][8192];
    bit m_lvl [3], m_press [3], m_rawp [3];
    int m_cyc, m_tick, m_digit;
    bit m_run, m_valid;
`ifdef SEQ_AUTOREPEAT_EN
    localparam int HALF = TD / 2;
    localparam int PER  = (TD / 8 > 1) ? TD / 8 : 1;
    int m_hold [3];
    function automatic bit rep(int k);
        return k == HALF || (k > HALF && (k - HALF) % PER == 0);
    endfunction
`endif

    task model_step();
        bit up, dn, runp, term, all;
        bit raw [3];
        int nd, c;
        if (!rst_n) begin
            m_cyc = 0; m_tick = 0; m_digit = 0; m_run = 1; m_valid = 0;
            for (int b = 0; b < 3; b++) begin
                m_lvl[b] = 0; m_press[b] = 0; m_rawp[b] = 0; hist[b][0] = 0;
`ifdef SEQ_AUTOREPEAT_EN
                m_hold[b] = -1;
`endif
            end
            return;
        end
        raw = '{btn_up, btn_down, btn_run};
        up = m_press[0];
        dn = m_press[1];
`ifdef SEQ_AUTOREPEAT_EN
        up = up || rep(m_hold[0]);
        dn = dn || rep(m_hold[1]);
`endif
        runp = m_press[2];
        term = m_run && m_tick == TD - 1;
        nd = m_digit;
        if (up && !dn) nd = nd + 1;
        else if (dn && !up) nd = nd - 1;
        else if (!up && !dn && term) nd = nd + 1;
        nd = (nd + 16) % 16;
        m_valid = nd != m_digit;
        m_digit = nd;
        if (up || dn || term || !m_run || runp) m_tick = 0;
        else m_tick = m_tick + 1;
        if (runp) m_run = !m_run;
        m_cyc = m_cyc + 1;
        c = m_cyc;
        for (int b = 0; b < 3; b++) begin
            all = c >= DB;
            for (int j = 1; j <= DB; j++) if (hist[b][(c - j) & 8191] == m_lvl[b]) all = 0;
            hist[b][c & 8191] = m_rawp[b];
            m_press[b] = all && !m_lvl[b];
            if (all) m_lvl[b] = !m_lvl[b];
`ifdef SEQ_AUTOREPEAT_EN
            m_hold[b] = m_lvl[b] ? m_hold[b] + 1 : -1;
`endif
            m_rawp[b] = raw[b];
        end
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    // ---------------- directed table ----------------
    typedef struct {
        logic up, dn, run;
        int   hold, wt, exp_digit;
        logic exp_run;
        int   exp_nv;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #5000000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        int nv, b;
        logic lv [3];
        int rem [3];
        tbl[0] = '{1'b0, 1'b1, 1'b0, 5, 14, 15, 1'b0, 1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 2, 14, 15, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 5, 14, 15, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 5, 14, 0,  1'b0, 1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 5, 14, 1,  1'b0, 1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 4, 14, 0,  1'b0, 1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 3, 14, 0,  1'b0, 0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 5, 4,  1,  1'b1, 1};

        // reset values
        @(negedge clk);
        chk("in_reset_digit", digit, 0);
        chk("in_reset_valid", digit_valid, 0);
        chk("in_reset_running", running, 1);
        do_reset();
        chk("rst_digit", digit, 0);
        chk("rst_running", running, 1);

        // free-running auto-advance and wrap
        nv = 0;
        for (int c = 1; c <= 160; c++) begin
            at(c);
            nv += digit_valid;
            if (c == 9)   chk("run_c9_digit", digit, 0);
            if (c == 9)   chk("run_c9_valid", digit_valid, 0);
            if (c == 10)  chk("run_c10_digit", digit, 1);
            if (c == 10)  chk("run_c10_valid", digit_valid, 1);
            if (c == 20)  chk("run_c20_digit", digit, 2);
            if (c == 30)  chk("run_c30_digit", digit, 3);
            if (c == 159) chk("run_c159_digit", digit, 15);
        end
        chk("wrap_c160_digit", digit, 0);
        chk("run_valid_count", nv, 16);

        // asynchronous reset mid-count, between clock edges
        at(165);
        #2 rst_n = 0;
        #1;
        chk("async_rst_digit", digit, 0);
        chk("async_rst_valid", digit_valid, 0);
        chk("async_rst_running", running, 1);
        @(negedge clk); rst_n = 1;

        // run press to PAUSE, digit frozen
        btn_run = 1;
        at(6); chk("pause_c6_running", running, 1);
        at(7); chk("pause_c7_running", running, 0);
        chk("pause_c7_digit", digit, 0);
        at(8); btn_run = 0;
        nv = 0;
        for (int c = 9; c <= 108; c++) begin
            at(c);
            nv += digit_valid;
        end
        chk("pause_frozen_digit", digit, 0);
        chk("pause_frozen_valids", nv, 0);

        // table of step patterns from PAUSE
        for (int i = 0; i < 8; i++) begin
            b = ecount;
            btn_up = tbl[i].up; btn_down = tbl[i].dn; btn_run = tbl[i].run;
            nv = 0;
            for (int c = b + 1; c <= b + tbl[i].hold + tbl[i].wt; c++) begin
                at(c);
                if (c == b + tbl[i].hold) begin btn_up = 0; btn_down = 0; btn_run = 0; end
                nv += digit_valid;
            end
            chk($sformatf("tbl%0d_digit", i), digit, tbl[i].exp_digit);
            chk($sformatf("tbl%0d_running", i), running, tbl[i].exp_run);
            chk($sformatf("tbl%0d_valids", i), nv, tbl[i].exp_nv);
        end

        // step pulse landing on terminal tick
        do_reset();
        at(10); chk("term_c10_digit", digit, 1);
        at(13); btn_up = 1;
        at(18); btn_up = 0;
        at(19); chk("term_c19_digit", digit, 1);
        at(20); chk("term_c20_digit", digit, 2);
        chk("term_c20_valid", digit_valid, 1);
        nv = 0;
        for (int c = 21; c <= 29; c++) begin
            at(c);
            nv += digit_valid;
        end
        chk("term_c29_digit", digit, 2);
        chk("term_gap_valids", nv, 0);
        at(30); chk("term_c30_digit", digit, 3);

        // long hold in PAUSE
        do_reset();
        btn_run = 1;
        at(8); btn_run = 0;
        at(20); btn_up = 1;
        nv = 0;
        for (int c = 21; c <= 60; c++) begin
            at(c);
            if (c == 40) btn_up = 0;
            nv += digit_valid;
            if (c == 26) chk("hold_c26_digit", digit, 0);
            if (c == 27) chk("hold_c27_digit", digit, 1);
        end
`ifdef SEQ_AUTOREPEAT_EN
        chk("hold_final_digit", digit, 0);
        chk("hold_valids", nv, 16);
`else
        chk("hold_final_digit", digit, 1);
        chk("hold_valids", nv, 1);
`endif

        // randomized buttons against the reference model
        do_reset();
        for (int k = 0; k < 3; k++) begin lv[k] = 0; rem[k] = 0; end
        for (int i = 0; i < 3000; i++) begin
            at(i);
            chk("rand_outputs", int'({digit, digit_valid, running}), int'({4'(m_digit), m_valid, m_run}));
            for (int k = 0; k < 3; k++) begin
                if (rem[k] == 0) begin
                    lv[k]  = (k == 2) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
                    rem[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(4, 14);
                    if (k == 2 && !lv[k]) rem[k] = rem[k] * 4;
                end
                rem[k] = rem[k] - 1;
            end
            btn_up = lv[0]; btn_down = lv[1]; btn_run = lv[2];
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
